// File: rtl/regfile_pkg.sv
// Shared constants and types for the writeback arbiter and the register file.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Requester index as seen by the round-robin grant vector.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LD  = 1'b1
    } req_idx_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback offers, scoreboard reserve/check and register-file write port bundle.
interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int XLEN = 32
);

    logic            alu_valid;
    reg_addr_t       alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;

    logic            ld_valid;
    reg_addr_t       ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            ld_ready;

    logic            rsv_valid;
    reg_addr_t       rsv_rd;
    reg_addr_t       chk_rs1;
    reg_addr_t       chk_rs2;
    logic            stall;

    reg_addr_t       rd;
    logic [XLEN-1:0] rdv;
    logic            reg_wen;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output rsv_valid, rsv_rd, chk_rs1, chk_rs2,
        input  alu_ready, ld_ready, stall,
        input  rd, rdv, reg_wen
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  rsv_valid, rsv_rd, chk_rs1, chk_rs2,
        output alu_ready, ld_ready, stall,
        output rd, rdv, reg_wen
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last winner loses the next contested cycle.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_gnt_q;
    logic last_gnt_d;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_gnt_q ? 2'b01 : 2'b10;
        end
        last_gnt_d = last_gnt_q;
        if (gnt != 2'b00) begin
            last_gnt_d = gnt[1];
        end
    end

    // Reset value 1 makes requester 0 win the first contest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU/load writebacks onto one register-file write port and tracks
// outstanding writes in a scoreboard that drives the issue-stage stall.
module regfile_wb_arbiter #(
    parameter int XLEN  = regfile_pkg::XLEN,
    parameter int NREGS = regfile_pkg::NREGS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);

    import regfile_pkg::*;

    logic [1:0]       gnt;
    logic             accept;
    reg_addr_t        sel_rd;
    logic [XLEN-1:0]  sel_data;

    logic             reg_wen_q, reg_wen_d;
    reg_addr_t        rd_q, rd_d;
    logic [XLEN-1:0]  rdv_q, rdv_d;
    logic [NREGS-1:0] pending_q, pending_d;
    logic             byp1, byp2;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({bus.ld_valid, bus.alu_valid}),
        .gnt   (gnt)
    );

    // Ready is forced low while reset is held, independent of the valids.
    assign bus.alu_ready = gnt[REQ_ALU] & rst_n;
    assign bus.ld_ready  = gnt[REQ_LD]  & rst_n;
    assign accept        = bus.alu_ready | bus.ld_ready;

    always_comb begin
        sel_rd    = gnt[REQ_LD] ? bus.ld_rd   : bus.alu_rd;
        sel_data  = gnt[REQ_LD] ? bus.ld_data : bus.alu_data;
        reg_wen_d = accept && (sel_rd != '0);
        rd_d      = reg_wen_d ? sel_rd   : rd_q;
        rdv_d     = reg_wen_d ? sel_data : rdv_q;
    end

    // Scoreboard: a reservation on the same edge as the retiring write wins.
    assign pending_d[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_pending
            assign pending_d[gi] =
                (bus.rsv_valid && (bus.rsv_rd == reg_addr_t'(gi))) ||
                (pending_q[gi] && !(reg_wen_q && (rd_q == reg_addr_t'(gi))));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_wen_q <= 1'b0;
            rd_q      <= '0;
            rdv_q     <= '0;
            pending_q <= '0;
        end else begin
            reg_wen_q <= reg_wen_d;
            rd_q      <= rd_d;
            rdv_q     <= rdv_d;
            pending_q <= pending_d;
        end
    end

    assign byp1      = reg_wen_q && (rd_q == bus.chk_rs1);
    assign byp2      = reg_wen_q && (rd_q == bus.chk_rs2);
    assign bus.stall = rst_n && ((pending_q[bus.chk_rs1] && !byp1) ||
                                 (pending_q[bus.chk_rs2] && !byp2));

    assign bus.reg_wen = reg_wen_q;
    assign bus.rd      = rd_q;
    assign bus.rdv     = rdv_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus randomized traffic checked against a behavioural model.
module tb_regfile_wb_arbiter;

    import regfile_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.XLEN(32)) bus ();

    regfile_wb_arbiter #(.XLEN(32), .NREGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register file fed by the DUT write port; x0 must never be written.
    logic [31:0] rf [32];
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    always @(posedge clk) if (rst_n && bus.reg_wen) rf[bus.rd] <= bus.rdv;

    // Behavioural model: last winner, pending set, and the write-port register.
    bit          m_pend [32];
    bit          m_last;
    bit          m_wen;
    logic [4:0]  m_rd;
    logic [31:0] m_rdv;

    function automatic logic [31:0] pend_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_last = 1'b1;
        m_wen  = 1'b0;
        m_rd   = '0;
        m_rdv  = '0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_alu_ready", bus.alu_ready, 0);
                check("rst_ld_ready", bus.ld_ready, 0);
                check("rst_stall", bus.stall, 0);
                check("rst_reg_wen", bus.reg_wen, 0);
                check("rst_rd", bus.rd, 0);
                check("rst_rdv", bus.rdv, 0);
                check("rst_pending", dut.pending_q, 0);
                model_reset();
            end else begin
                int  g;
                bit  exp_stall;
                logic [4:0] r;
                g = -1;
                if (bus.alu_valid && bus.ld_valid) g = m_last ? 0 : 1;
                else if (bus.alu_valid)            g = 0;
                else if (bus.ld_valid)             g = 1;
                exp_stall = 1'b0;
                if (m_pend[bus.chk_rs1] && !(m_wen && m_rd == bus.chk_rs1)) exp_stall = 1'b1;
                if (m_pend[bus.chk_rs2] && !(m_wen && m_rd == bus.chk_rs2)) exp_stall = 1'b1;
                check("alu_ready", bus.alu_ready, (g == 0));
                check("ld_ready", bus.ld_ready, (g == 1));
                check("stall", bus.stall, exp_stall);
                check("reg_wen", bus.reg_wen, m_wen);
                if (m_wen) begin
                    check("rd", bus.rd, m_rd);
                    check("rdv", bus.rdv, m_rdv);
                end
                check("pending", dut.pending_q, pend_vec());
                // Advance to the state after the coming rising edge.
                if (m_wen) m_pend[m_rd] = 1'b0;
                if (bus.rsv_valid && bus.rsv_rd != 0) m_pend[bus.rsv_rd] = 1'b1;
                m_wen = 1'b0;
                if (g >= 0) begin
                    m_last = (g == 1);
                    r = (g == 1) ? bus.ld_rd : bus.alu_rd;
                    if (r != 0) begin
                        m_wen = 1'b1;
                        m_rd  = r;
                        m_rdv = (g == 1) ? bus.ld_data : bus.alu_data;
                    end
                end
            end
        end
    end

    task automatic idle();
        bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.ld_valid  = 0; bus.ld_rd  = '0; bus.ld_data  = '0;
        bus.rsv_valid = 0; bus.rsv_rd = '0;
        bus.chk_rs1   = '0; bus.chk_rs2 = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        bus.alu_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_alu_ready_lit", bus.alu_ready, 0);
        check("reset_reg_wen_lit", bus.reg_wen, 0);
        check("reset_rd_lit", bus.rd, 0);
        check("reset_rdv_lit", bus.rdv, 0);
        check("reset_stall_lit", bus.stall, 0);

        // ALU alone, offered in the first cycle after release.
        step();
        rst_n = 1'b1;
        idle();
        bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEAEEFFA;
        #1;
        check("alu_only_ready", bus.alu_ready, 1);
        check("alu_only_ld_ready", bus.ld_ready, 0);
        step(); idle();
        #1;
        check("alu_only_wen", bus.reg_wen, 1);
        check("alu_only_rd", bus.rd, 5);
        check("alu_only_rdv", bus.rdv, 32'hDEAEEFFA);

        // Load to x0: accepted, but no write.
        step();
        bus.ld_valid = 1; bus.ld_rd = 5'd0; bus.ld_data = 32'h12345678;
        #1;
        check("x0_ld_ready", bus.ld_ready, 1);
        step(); idle();
        #1;
        check("x0_wen", bus.reg_wen, 0);
        step();
        check("x0_rf_read", rf[0], 32'h0);

        // Contest: ALU, load, ALU, load.
        for (int k = 0; k < 4; k++) begin
            if (k != 0) step();
            bus.alu_valid = 1; bus.alu_rd = 5'd1; bus.alu_data = 32'h11110000 + k;
            bus.ld_valid  = 1; bus.ld_rd  = 5'd2; bus.ld_data  = 32'h22220000 + k;
            #1;
            check("rr_alu_ready", bus.alu_ready, (k % 2 == 0));
            check("rr_ld_ready", bus.ld_ready, (k % 2 == 1));
            if (k > 0) begin
                check("rr_wen", bus.reg_wen, 1);
                check("rr_rd", bus.rd, ((k - 1) % 2 == 0) ? 1 : 2);
            end
        end
        step(); idle();
        #1;
        check("rr_last_wen", bus.reg_wen, 1);
        check("rr_last_rd", bus.rd, 2);
        check("rr_last_rdv", bus.rdv, 32'h22220003);

        // Reserve x10, stall, then bypass on the retiring write.
        step();
        bus.rsv_valid = 1; bus.rsv_rd = 5'd10;
        step();
        bus.rsv_valid = 0; bus.chk_rs1 = 5'd10;
        bus.alu_valid = 1; bus.alu_rd = 5'd10; bus.alu_data = 32'hCAFECAFE;
        #1;
        check("x10_stall", bus.stall, 1);
        step();
        bus.alu_valid = 0;
        #1;
        check("x10_wen", bus.reg_wen, 1);
        check("x10_rdv", bus.rdv, 32'hCAFECAFE);
        check("x10_bypass_stall", bus.stall, 0);
        step();
        check("x10_after_stall", bus.stall, 0);
        check("x10_pending", dut.pending_q[10], 0);

        // Re-reserve x7 on the edge where its write retires: set wins.
        idle();
        bus.rsv_valid = 1; bus.rsv_rd = 5'd7;
        bus.alu_valid = 1; bus.alu_rd = 5'd7; bus.alu_data = 32'h00000077;
        step();
        bus.alu_valid = 0; bus.chk_rs2 = 5'd7;
        #1;
        check("x7_wen", bus.reg_wen, 1);
        check("x7_bypass_stall", bus.stall, 0);
        step();
        bus.rsv_valid = 0;
        #1;
        check("x7_pending", dut.pending_q[7], 1);
        check("x7_stall", bus.stall, 1);

        // Reset mid-cycle right after an accepted transfer.
        step();
        bus.alu_valid = 1; bus.alu_rd = 5'd3; bus.alu_data = 32'h00000033;
        step();
        check("rstmid_wen_before", bus.reg_wen, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstmid_wen", bus.reg_wen, 0);
        check("rstmid_stall", bus.stall, 0);
        check("rstmid_pending", dut.pending_q, 0);
        check("rstmid_alu_ready", bus.alu_ready, 0);
        @(posedge clk);
        step();
        rst_n = 1'b1;
        idle();
        step();
        check("rstmid_no_write", bus.reg_wen, 0);

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 1500; c++) begin
            step();
            bus.alu_valid = ($urandom_range(0, 1) == 1);
            bus.alu_rd    = 5'($urandom_range(0, 7));
            bus.alu_data  = $urandom;
            bus.ld_valid  = ($urandom_range(0, 1) == 1);
            bus.ld_rd     = 5'($urandom_range(0, 7));
            bus.ld_data   = $urandom;
            bus.rsv_valid = ($urandom_range(0, 9) < 3);
            bus.rsv_rd    = 5'($urandom_range(0, 7));
            bus.chk_rs1   = 5'($urandom_range(0, 7));
            bus.chk_rs2   = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
        end

        step(); idle();
        step(); step();
        check("final_rf_x0", rf[0], 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data width of register-file write data.
REQ-002 Parameter NREGS, default 32, number of architectural registers; address width is 5.
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port alu_valid / alu_rd / alu_data  in  1 / 5 / XLEN  requester 0 (ALU) writeback offer.
REQ-006 Port alu_ready  out  1  requester 0 accepted this cycle.
REQ-007 Port ld_valid / ld_rd / ld_data  in  1 / 5 / XLEN  requester 1 (load unit) writeback offer.
REQ-008 Port ld_ready  out  1  requester 1 accepted this cycle.
REQ-009 Port rsv_valid / rsv_rd  in  1 / 5  issue stage marks rsv_rd as pending-write.
REQ-010 Port chk_rs1 / chk_rs2  in  5 / 5  source registers of the instruction in issue.
REQ-011 Port stall  out  1  issue must hold; a source has an outstanding write.
REQ-012 Port rd / rdv / reg_wen  out  5 / XLEN / 1  drive the register file write port.

Function
REQ-013 Transfer occurs when valid and ready are both high in the same cycle; ready is combinational from valid and arbiter state.
REQ-014 At most one requester is granted per cycle; ready is high only for the granted requester.
REQ-015 Single valid requester is granted unconditionally, regardless of the other's state.
REQ-016 Both valid: grant goes to the requester not granted last (1-bit round-robin pointer last_gnt).
REQ-017 last_gnt updates to the granted index on every grant, contested or not; holds when no grant.
REQ-018 Write latency is exactly 1 cycle: data accepted in cycle N appears on rd/rdv with reg_wen=1 in cycle N+1.
REQ-019 A granted transfer with rd=0 is accepted (ready=1) but produces reg_wen=0 in cycle N+1.
REQ-020 No grant in cycle N gives reg_wen=0 in cycle N+1; rd/rdv hold their last values.
REQ-021 Scoreboard: NREGS-bit vector pending; bit 0 is hard-wired 0.
REQ-022 rsv_valid with rsv_rd != 0 sets pending[rsv_rd] at the clock edge.
REQ-023 pending[rd] clears at the end of any cycle in which reg_wen=1.
REQ-024 Set and clear of the same register on the same edge: set wins (new producer).
REQ-025 stall = (pending[chk_rs1] and not bypass1) or (pending[chk_rs2] and not bypass2), where bypassN = reg_wen and rd == chk_rsN; register x0 never stalls.
REQ-026 stall is combinational from current-cycle state and inputs only (no registered delay).
REQ-027 A write to a register that is not pending is performed normally and leaves pending unchanged.

Reset
REQ-028 rst_n low asynchronously forces reg_wen=0, rd=0, rdv=0, pending=all zeros, last_gnt=1 (ALU wins first contest).
REQ-029 While rst_n is low, alu_ready=0, ld_ready=0, stall=0.
REQ-030 A transfer accepted in the cycle before reset asserts is discarded; no write is issued after reset releases.
REQ-031 First grant is possible in the first clock cycle after rst_n deasserts.

Structure
REQ-032 Package regfile_pkg holds XLEN, REG_ADDR_W=5, NREGS and typedef reg_addr_t; the block and the register file both import it.
REQ-033 The two-way round-robin grant logic with its last_gnt flop is a sub-module rr_arbiter2 (req[1:0] in, gnt[1:0] out, clk/rst_n).
REQ-034 Scoreboard and write-output register stay in regfile_wb_arbiter; it connects directly to register_file rd/rdv/reg_wen.

Verification
REQ-035 Reset, then ALU alone offers rd=5, data 0xDEAEEFFA -> alu_ready=1 same cycle; next cycle reg_wen=1, rd=5, rdv=0xDEAEEFFA.
REQ-036 Both valid for 4 cycles (ALU rd=1, load rd=2) -> grants ALU, load, ALU, load; reg_wen=1 every cycle from cycle 2 on.
REQ-037 Load offers rd=0, data 0x12345678 -> ld_ready=1; next cycle reg_wen=0; an x0 read in the register file returns 0x00000000.
REQ-038 rsv rd=10, then chk_rs1=10 -> stall=1; ALU writes 0xCAFECAFE to x10 -> stall=0 in the reg_wen cycle (bypass); pending[10]=0 afterwards.
REQ-039 rsv_valid rd=7 in the same cycle reg_wen=1 with rd=7 -> pending[7]=1 afterwards; chk_rs2=7 still stalls.
REQ-040 rst_n dropped mid-cycle after an accepted transfer -> reg_wen, pending and stall read 0 immediately; no write after release.
